// File: rtl/alu_pkg.sv
// Shared types for the ALU command driver: function selects,
// sequencer states and the packed {func, a} command word.
package alu_pkg;

  localparam logic [2:0] FN_RCA       = 3'd0;
  localparam logic [2:0] FN_ADD       = 3'd1;
  localparam logic [2:0] FN_XNOR_NAND = 3'd2;
  localparam logic [2:0] FN_ANY       = 3'd3;
  localparam logic [2:0] FN_PATTERN   = 3'd4;
  localparam logic [2:0] FN_CONCAT    = 3'd5;
  localparam logic [2:0] FN_HOLD      = 3'd6;
  localparam logic [2:0] FN_INVALID   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FIN
  } state_e;

  typedef struct packed {
    logic [2:0] func;
    logic [3:0] a;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Circular command queue, DEPTH x 7 bits, pointers wrap mod DEPTH.
// Ports: push/wdata in, pop/rdata (head) out, count/full/empty.
module cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  cmd_t                     wdata,
  input  logic                     pop,
  output cmd_t                     rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + AW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Queues {func,a} commands, then issues them to the ALU and captures results.
// Ports: clock/resetn, load/cmd_in/start in; alu_* to ALU; alu_result back;
// result_q/count/busy/done/overflow/bad_cmd/checksum status out.
// Macro ALU_DRV_CHECKSUM_EN builds the per-run XOR checksum accumulator.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   load,
  input  logic [6:0]             cmd_in,
  input  logic                   start,
  output logic [2:0]             alu_func,
  output logic [3:0]             alu_a,
  output logic                   alu_valid,
  input  logic [7:0]             alu_result,
  output logic [7:0]             result_q,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   bad_cmd,
  output logic [7:0]             checksum
);

  state_e     state_q, state_d;
  logic [2:0] alu_func_q, alu_func_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic       alu_valid_q, alu_valid_d;
  logic [7:0] result_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       overflow_q, overflow_d;
  logic       bad_cmd_q, bad_cmd_d;

  cmd_t cmd_w;
  cmd_t head;
  logic push, pop;
  logic full, empty;
  logic idle;
  logic ck_clr, ck_acc;

  assign cmd_w = cmd_in;
  assign idle  = (state_q == ST_IDLE);
  assign push  = load && idle && (cmd_w.func != FN_INVALID) && !full;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .wdata  (cmd_w),
    .pop    (pop),
    .rdata  (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    state_d     = state_q;
    alu_func_d  = alu_func_q;
    alu_a_d     = alu_a_q;
    alu_valid_d = 1'b0;
    result_d    = result_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    bad_cmd_d   = bad_cmd_q;
    pop         = 1'b0;
    ck_clr      = 1'b0;
    ck_acc      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load && cmd_w.func == FN_INVALID) begin
          bad_cmd_d = 1'b1;
        end else if (load && full) begin
          overflow_d = 1'b1;
        end
        if (start && !empty) begin
          // Head is popped as ISSUE is entered so alu_* are registered.
          state_d     = ST_ISSUE;
          pop         = 1'b1;
          alu_func_d  = head.func;
          alu_a_d     = head.a;
          alu_valid_d = 1'b1;
          busy_d      = 1'b1;
          ck_clr      = 1'b1;
        end else if (start) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        result_d = alu_result;
        ck_acc   = 1'b1;
        if (empty) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d     = ST_ISSUE;
          pop         = 1'b1;
          alu_func_d  = head.func;
          alu_a_d     = head.a;
          alu_valid_d = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      alu_func_q  <= '0;
      alu_a_q     <= '0;
      alu_valid_q <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      bad_cmd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_func_q  <= alu_func_d;
      alu_a_q     <= alu_a_d;
      alu_valid_q <= alu_valid_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      bad_cmd_q   <= bad_cmd_d;
    end
  end

  assign alu_func  = alu_func_q;
  assign alu_a     = alu_a_q;
  assign alu_valid = alu_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign bad_cmd   = bad_cmd_q;

`ifdef ALU_DRV_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (ck_clr) begin
      checksum_d = '0;
    end else if (ck_acc) begin
      checksum_d = checksum_q ^ alu_result;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  logic unused_ck;
  assign unused_ck = ck_clr ^ ck_acc;
  assign checksum  = 8'h00;
`endif

endmodule
